// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-flop line synchroniser, mid-bit sampling FSM and a
// show-ahead byte FIFO drained by a valid/ready consumer.
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  input  logic                          clear_i,
  output logic                          busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            ferr_d;
  logic            push;
  logic            rx_meta, rx_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      frame_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      frame_err_o <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = 3'd0;
            cnt_d   = FULL_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit gives half a bit of slack for the next start.
        if (cnt_q == '0) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;
  logic          pop, full, wr_en, ovr_set;

  assign pop     = rx_valid_o && rx_ready_i;
  assign full    = (level_q == LW'(FIFO_DEPTH));
  // When full, a same-cycle pop frees the slot the push lands in.
  assign wr_en   = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shreg_q;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (ovr_set)      overrun_o <= 1'b1;
      else if (clear_i) overrun_o <= 1'b0;
    end
  end

  assign rx_data_o  = mem[rd_ptr];
  assign rx_valid_o = (level_q != '0);
  assign level_o    = level_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised scoreboard bench for uart_rx_fifo: a serial driver pushes the
// bytes it expects to be stored, a monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CLK_FREQ_HZ = 25000000;
  localparam int BAUD_RATE   = 115200;
  localparam int FIFO_DEPTH  = 4;
  localparam int CPB         = CLK_FREQ_HZ / BAUD_RATE;
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;

  logic          clk, rst_ni, rx_i, rx_ready_i, clear_i;
  logic [7:0]    rx_data_o;
  logic          rx_valid_o, frame_err_o, overrun_o, busy_o;
  logic [LW-1:0] level_o;

  logic [7:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         ferr_count = 0;
  int         ferr_base;
  bit         exp_ovr = 0;
  bit         rand_done;

  uart_rx_fifo #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .rx_i(rx_i), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .level_o(level_o),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o), .clear_i(clear_i),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Handshake: a byte transfers on a rising edge where rx_valid_o && rx_ready_i.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni && rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: actual=0x%0h required=no byte", rx_data_o);
        end else begin
          check("pop_data", {24'd0, rx_data_o}, {24'd0, exp_q.pop_front()});
        end
      end
      if (rst_ni && frame_err_o) ferr_count++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // The byte is expected unless the FIFO is full with no pop at the push.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_push);
    rx_i = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_clks(CPB);
    end
    rx_i = stop;
    if (stop) begin
      if (exp_q.size() < FIFO_DEPTH || pop_at_push) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end
    wait_clks(CPB);
    rx_i = 1'b1;
  endtask

  task automatic drain(input int n);
    rx_ready_i = 1'b1;
    wait_clks(n);
    rx_ready_i = 1'b0;
    check("drain_empty_q", exp_q.size(), 0);
    check("drain_level", {{(32-LW){1'b0}}, level_o}, 0);
  endtask

  initial begin
    rst_ni = 1'b0; rx_i = 1'b1; rx_ready_i = 1'b0; clear_i = 1'b0;
    wait_clks(3);
    check("reset_level", {{(32-LW){1'b0}}, level_o}, 0);
    check("reset_valid", {31'd0, rx_valid_o}, 0);
    check("reset_data", {24'd0, rx_data_o}, 0);
    check("reset_busy", {31'd0, busy_o}, 0);
    check("reset_ovr", {31'd0, overrun_o}, 0);
    rst_ni = 1'b1;
    wait_clks(2);

    // Single byte
    send_frame(8'hA5, 1'b1, 1'b0);
    check("t1_valid", {31'd0, rx_valid_o}, 1);
    check("t1_data", {24'd0, rx_data_o}, 32'hA5);
    check("t1_level", {{(32-LW){1'b0}}, level_o}, 1);
    drain(1);
    check("t1_valid_after", {31'd0, rx_valid_o}, 0);

    // Glitch shorter than half a bit
    ferr_base = ferr_count;
    rx_i = 1'b0;
    wait_clks(50);
    rx_i = 1'b1;
    wait_clks(2 * CPB);
    check("t2_busy", {31'd0, busy_o}, 0);
    check("t2_level", {{(32-LW){1'b0}}, level_o}, 0);
    check("t2_ferr", ferr_count - ferr_base, 0);

    // Framing error followed by a held-low line, then a good byte
    ferr_base = ferr_count;
    rx_i = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = ((8'h3C >> i) & 8'h01) != 0;
      wait_clks(CPB);
    end
    rx_i = 1'b0;
    wait_clks(4 * CPB);
    rx_i = 1'b1;
    wait_clks(CPB);
    send_frame(8'h7E, 1'b1, 1'b0);
    check("t3_ferr_pulses", ferr_count - ferr_base, 1);
    check("t3_level", {{(32-LW){1'b0}}, level_o}, 1);
    drain(2);

    // Overrun
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("t4_level", {{(32-LW){1'b0}}, level_o}, FIFO_DEPTH);
    check("t4_ovr", {31'd0, overrun_o}, {31'd0, exp_ovr});
    drain(6);
    clear_i = 1'b1;
    wait_clks(1);
    clear_i = 1'b0;
    exp_ovr = 1'b0;
    check("t4_ovr_clear", {31'd0, overrun_o}, 0);

    // Push and pop in the same cycle at full
    for (int i = 0; i < FIFO_DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    fork
      send_frame(8'h55, 1'b1, 1'b1);
      begin
        // Push edge: 2 sync edges + 1 to START, CPB/2 to start sample, 9*CPB to stop sample.
        wait_clks(3 + CPB / 2 + 9 * CPB - 1);
        rx_ready_i = 1'b1;
        wait_clks(1);
        rx_ready_i = 1'b0;
      end
    join
    check("t5_level", {{(32-LW){1'b0}}, level_o}, FIFO_DEPTH);
    check("t5_ovr", {31'd0, overrun_o}, 0);
    drain(6);

    // Reset during data bit 4, with a byte already buffered
    send_frame(8'h99, 1'b1, 1'b0);
    rx_i = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_i = ((8'hF0 >> i) & 8'h01) != 0;
      wait_clks(CPB);
    end
    rx_i = 1'b1;
    wait_clks(CPB / 2);
    rst_ni = 1'b0;
    wait_clks(2);
    check("t6_level", {{(32-LW){1'b0}}, level_o}, 0);
    check("t6_valid", {31'd0, rx_valid_o}, 0);
    check("t6_data", {24'd0, rx_data_o}, 0);
    check("t6_ferr", {31'd0, frame_err_o}, 0);
    check("t6_ovr", {31'd0, overrun_o}, 0);
    check("t6_busy", {31'd0, busy_o}, 0);
    exp_q.delete();
    wait_clks(3);
    rst_ni = 1'b1;
    wait_clks(CPB);
    send_frame(8'h0F, 1'b1, 1'b0);
    check("t6_level_after", {{(32-LW){1'b0}}, level_o}, 1);
    check("t6_data_after", {24'd0, rx_data_o}, 32'h0F);
    drain(2);

    // Random bytes, random gaps (including back-to-back), random consumer
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          int gap;
          gap = $urandom_range(0, 2);
          if (gap != 0) wait_clks(gap * (CPB / 2));
          send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rx_ready_i = 1'($urandom_range(0, 1));
          wait_clks(1);
        end
        rx_ready_i = 1'b0;
      end
    join
    drain(FIFO_DEPTH + 2);
    check("rand_ovr", {31'd0, overrun_o}, 0);
    check("final_ferr_total", ferr_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial UART receiver for the FPGA top level, the receiving end of the 8N1 serial link whose transmit side is the core subsystem's `ser_tx` output. It resynchronises the asynchronous line and detects start bits. It samples each bit at mid-bit, checks the stop bit, and buffers received bytes in a small show-ahead FIFO. A downstream consumer drains the FIFO with a valid/ready handshake, for example an LED/status decoder or a loopback transmitter. Line errors are reported through a framing-error pulse and a sticky overrun flag.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 25000000: system clock frequency.
- `BAUD_RATE`, default 115200: line rate. `CLKS_PER_BIT` = `CLK_FREQ_HZ / BAUD_RATE` (integer division; 217 at defaults). It must be ≥ 8.
- `FIFO_DEPTH`, default 4: number of byte entries. Must be a power of 2, ≥ 2.

Ports:
- `clk_i`, input, 1: system clock.
- `rst_ni`, input, 1: reset, asynchronous and active-low.
- `rx_i`, input, 1: asynchronous serial line; idles high.
- `rx_data_o`, output, 8: byte at the FIFO head.
- `rx_valid_o`, output, 1: FIFO not empty.
- `rx_ready_i`, input, 1: consumer accepts the head byte.
- `level_o`, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `frame_err_o`, output, 1: one-cycle pulse when a stop bit is sampled low.
- `overrun_o`, output, 1: sticky flag; a byte was dropped because the FIFO was full.
- `clear_i`, input, 1: clears `overrun_o`.
- `busy_o`, output, 1: FSM is not in IDLE.

## Operation
- Synchroniser:
  - `rx_i` passes through a 2-flop synchroniser; the flops reset to 1.
  - All decisions use the synchronised value `rx_s`.
- FSM states and transitions:
  - IDLE → START when `rx_s`=0. Load the bit counter with `CLKS_PER_BIT/2`-1.
  - START: when the counter reaches 0, sample `rx_s`.
    - Sample = 1: false start; return to IDLE.
    - Sample = 0: go to DATA, bit index = 0, counter = `CLKS_PER_BIT`-1.
  - DATA: each time the counter reaches 0, shift `rx_s` into the shift register LSB-first and reload the counter. After the 8th sample, go to STOP with counter = `CLKS_PER_BIT`-1.
  - STOP, when the counter reaches 0:
    - `rx_s`=1: push the byte (subject to the FIFO rules below), then → IDLE.
    - `rx_s`=0: pulse `frame_err_o`, discard the byte, → BREAK.
  - BREAK → IDLE on the first cycle `rx_s`=1. A held-low line therefore produces exactly one `frame_err_o`.
  - The FSM returns to IDLE at mid-stop-bit. A start bit that immediately follows is detected without loss.
- FIFO:
  - Show-ahead: `rx_data_o` is always the head entry.
  - Pop when `rx_valid_o` && `rx_ready_i`.
  - Push on a good stop bit:
    - FIFO not full: the byte is written.
    - FIFO full and no pop this cycle: the byte is dropped and `overrun_o` is set.
    - FIFO full with a pop in the same cycle: both the pop and the push happen, the level is unchanged, and there is no overrun.
  - `rx_data_o` is don't-care while `rx_valid_o`=0; it is 0 after reset.
- Flags:
  - `clear_i` clears `overrun_o`. If `clear_i` and a new overrun occur in the same cycle, set wins.
  - `frame_err_o` is not sticky.
- Reset, including mid-frame:
  - FSM → IDLE; FIFO empty, so `level_o`=0 and `rx_valid_o`=0.
  - `rx_data_o`=0, `frame_err_o`=0, `overrun_o`=0, `busy_o`=0.
  - A partial frame is lost.

## Timing
- Start detection: a falling edge on `rx_i` reaches `rx_s` after 2 clock edges. The FSM enters START on the next edge, and `busy_o` rises in that cycle.
- Start-bit sample: `CLKS_PER_BIT/2` cycles after START entry.
- Data bit n (n = 0..7) is sampled (n+1)·`CLKS_PER_BIT` cycles after the start-bit sample. The stop bit is sampled 9·`CLKS_PER_BIT` cycles after the start-bit sample.
- Push latency: `rx_valid_o` and `level_o` update on the edge after the stop-bit sample. `frame_err_o` is high in that same cycle.
- Pop: `level_o` decrements and `rx_data_o` advances on the edge where the pop handshake completes. There are no wait states, so back-to-back pops are allowed every cycle.
- Glitch rejection: a low pulse shorter than about `CLKS_PER_BIT/2` cycles produces no byte and no error.

## Test plan
Defaults (217 clocks per bit) unless stated otherwise.

1. Single byte: send 0xA5 with `rx_ready_i`=0.
   - `rx_valid_o`=1, `rx_data_o`=0xA5, `level_o`=1.
   - After one cycle with `rx_ready_i`=1: `level_o`=0 and `rx_valid_o`=0.
2. Glitch: drive `rx_i` low for 50 cycles, then high.
   - FSM returns to IDLE; `level_o`=0, `frame_err_o` never asserts.
3. Framing error: send 0x3C with stop bit = 0, then hold the line low for 3 bit times, then send 0x7E normally.
   - Exactly one `frame_err_o` pulse.
   - Only 0x7E enters the FIFO.
4. Overrun: send 0x01..0x05 back-to-back with `rx_ready_i`=0 (depth 4).
   - `level_o`=4, `overrun_o`=1.
   - Draining yields 0x01, 0x02, 0x03, 0x04.
   - Pulsing `clear_i` sets `overrun_o`=0.
5. Simultaneous push/pop at full: fill the FIFO with 4 bytes, then send 0x55 and hold `rx_ready_i`=1 exactly on the push cycle.
   - `level_o` stays 4, `overrun_o`=0.
   - Tail entry is 0x55.
6. Reset mid-frame: assert `rst_ni`=0 during data bit 4 of 0xF0, then release and send 0x0F.
   - Every output is at its reset value while reset is held.
   - Afterwards, only 0x0F is received.
